// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - BCD digit width
//   - shift-and-add-3 adjust threshold and offset
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int BCD_W = 4;

    // A digit of 5 or more doubles past 9, so it is pre-corrected by +3.
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_OFFSET = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational per-digit correction cell for double-dabble conversion.
// Adds 3 to a BCD digit that is 5 or more, so the following left shift
// carries correctly into the next decimal digit.
// Ports:
//   digit_i  in   4  scratch BCD digit before the shift
//   digit_o  out  4  corrected digit (4-bit wrap, no carry out)
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i + ADJ_OFFSET) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter, one bit per clock (double dabble).
// A start pulse in IDLE captures bin; WIDTH shift cycles later the result
// appears on bcd together with a one-cycle done strobe.
// Optional feature macro: BIN2BCD_BLANK_EN adds the registered leading-zero
// mask output blank.
// Ports:
//   clk    in   1          system clock, rising edge
//   rst    in   1          asynchronous, active-high reset
//   start  in   1          conversion request, sampled only in IDLE
//   bin    in   WIDTH      binary operand, captured on accepted start
//   busy   out  1          high while state is not IDLE
//   done   out  1          one-cycle result-valid strobe
//   bcd    out  4*DIGITS   packed BCD, ones digit in bcd[3:0]
//   blank  out  DIGITS     leading-zero mask (BIN2BCD_BLANK_EN only)
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]       blank
`endif
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int SCR = BCD_W * DIGITS;
    localparam int SW  = SCR + WIDTH;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic [SCR-1:0]  bcd_q, bcd_d;
    logic [SCR-1:0]  adj_w;
    logic [SW-1:0]   shifted;

    // One correction cell per scratch digit, reused on every shift cycle.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (shreg_q[WIDTH + g*BCD_W +: BCD_W]),
            .digit_o (adj_w[g*BCD_W +: BCD_W])
        );
    end

    // Adjust first, then shift; the top bit of the register falls off.
    assign shifted = {adj_w, shreg_q[WIDTH-1:0]} << 1;

    // Next-state logic: load on start, shift WIDTH times, then present the
    // result for exactly one DONE cycle. start is ignored outside IDLE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d = {{SCR{1'b0}}, bin};
                    count_d = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d = shifted;
                count_d = count_q + CW'(1);
                // Last shift: publish the scratch digits on the same edge.
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    bcd_d   = shifted[SW-1:WIDTH];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, shift register and result register. Reset discards
    // any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            shreg_q <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign bcd  = bcd_q;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              zeroAbove;

    // Blank a digit when it and every higher digit are zero. Derived from
    // bcd_d so the mask always tracks the registered result; the ones digit
    // is never blanked so a zero value still shows "0".
    always_comb begin
        blank_d   = '0;
        zeroAbove = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zeroAbove  = zeroAbove && (bcd_d[i*BCD_W +: BCD_W] == 4'd0);
            blank_d[i] = zeroAbove;
        end
        blank_d[0] = 1'b0;
    end

    // Mask register, reset to the pattern matching a zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Scoreboard bench for bin2bcd_seq. The driver pushes the expected decimal
// result and completion edge for each accepted start; a monitor pops an entry
// on every done strobe and compares. Define BIN2BCD_BLANK_EN to cover blank.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [WIDTH-1:0]  bin;
    logic              busy;
    logic              done;
    logic [BW-1:0]     bcd;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank;
`endif

    typedef struct {
        logic [BW-1:0]     bcd;
        logic [DIGITS-1:0] blank;
        int                doneEdge;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;
    int   edgeCount = 0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    // Free-running clock and an edge counter used to timestamp completions.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        edgeCount <= edgeCount + 1;
    end

    // Reference: decimal digits by repeated division.
    function automatic logic [BW-1:0] refBcd(input int v);
        logic [BW-1:0] r;
        int n;
        r = '0;
        n = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    // Reference: digits at or above the count of significant decimal digits
    // are blanked; zero counts as one significant digit.
    function automatic logic [DIGITS-1:0] refBlank(input int v);
        logic [DIGITS-1:0] b;
        int nd;
        int t;
        nd = 1;
        t  = v;
        while (t >= 10) begin
            t  = t / 10;
            nd = nd + 1;
        end
        for (int i = 0; i < DIGITS; i++) begin
            b[i] = (i >= nd);
        end
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)",
                     name, actual, expected, edgeCount);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge: pulse start for one cycle. When expectIt is
    // set the conversion must be accepted, so its result is queued.
    task automatic applyStimulus(input logic [WIDTH-1:0] v, input bit expectIt);
        exp_t e;
        start = 1'b1;
        bin   = v;
        if (expectIt) begin
            e.bcd      = refBcd(int'(v));
            e.blank    = refBlank(int'(v));
            e.doneEdge = edgeCount + 1 + WIDTH;
            expQ.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        bin   = WIDTH'($urandom);
        if (expectIt) begin
            checkOutput("busy_after_start", 32'(busy), 32'd1);
        end
    endtask

    // Monitor: every done strobe consumes one scoreboard entry; the cycle
    // after it must be idle with done already low.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("bcd_value", 32'(bcd), 32'(e.bcd));
                    checkOutput("done_edge", 32'(edgeCount), 32'(e.doneEdge));
`ifdef BIN2BCD_BLANK_EN
                    checkOutput("blank_mask", 32'(blank), 32'(e.blank));
`endif
                    @(negedge clk);
                    checkOutput("post_done_busy", 32'(busy), 32'd0);
                    checkOutput("post_done_done", 32'(done), 32'd0);
                end
            end
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        int extra;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        waitCycles(3);
        checkOutput("reset_bcd", 32'(bcd), 32'h000);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
`ifdef BIN2BCD_BLANK_EN
        checkOutput("reset_blank", 32'(blank), 32'b110);
`endif
        rst = 1'b0;
        waitCycles(1);

        // Basic full-scale value.
        applyStimulus(8'd255, 1'b1);
        waitCycles(WIDTH + 1);
        checkOutput("hold_bcd_255", 32'(bcd), 32'h255);

        // Reset three cycles into a conversion: no result, no done.
        applyStimulus(8'd200, 1'b0);
        waitCycles(2);
        rst = 1'b1;
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_bcd", 32'(bcd), 32'h000);
        checkOutput("midreset_done", 32'(done), 32'd0);
`ifdef BIN2BCD_BLANK_EN
        checkOutput("midreset_blank", 32'(blank), 32'b110);
`endif
        @(negedge clk);
        rst = 1'b0;
        waitCycles(WIDTH + 3);
        checkOutput("after_reset_busy", 32'(busy), 32'd0);

        // Zero, carry boundaries and blanking patterns.
        applyStimulus(8'd0,   1'b1); waitCycles(WIDTH + 1);
        applyStimulus(8'd99,  1'b1); waitCycles(WIDTH + 1);
        applyStimulus(8'd100, 1'b1); waitCycles(WIDTH + 1);
        applyStimulus(8'd128, 1'b1); waitCycles(WIDTH + 1);
        applyStimulus(8'd5,   1'b1); waitCycles(WIDTH + 1);
        applyStimulus(8'd50,  1'b1); waitCycles(WIDTH + 1);
        applyStimulus(8'd205, 1'b1); waitCycles(WIDTH + 1);

        // Starts while busy: one during SHIFT, one in the DONE cycle.
        applyStimulus(8'd42, 1'b1);
        waitCycles(2);
        applyStimulus(8'd7, 1'b0);
        waitCycles(5);
        applyStimulus(8'd7, 1'b0);
        checkOutput("ignore_busy_low", 32'(busy), 32'd0);
        waitCycles(WIDTH + 2);
        checkOutput("ignore_busy_idle", 32'(busy), 32'd0);
        checkOutput("ignore_hold_bcd", 32'(bcd), 32'h042);

        // Every value back to back at the minimum period of WIDTH+2.
        for (int v = 0; v < (1 << WIDTH); v++) begin
            applyStimulus(WIDTH'(v), 1'b1);
            waitCycles(WIDTH + 1);
        end

        // Random values with ignored junk starts and random idle gaps.
        for (int k = 0; k < 40; k++) begin
            applyStimulus(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), 1'b1);
            r     = $urandom_range(0, WIDTH - 1);
            extra = $urandom_range(0, 3);
            waitCycles(r);
            applyStimulus(WIDTH'($urandom), 1'b0);
            waitCycles(WIDTH - r + extra);
        end

        waitCycles(WIDTH + 3);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
